// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between the execute stage (req 0)
// and the branch/compare unit (req 1), with registered results and a saturating op counter.
module alu_arbiter #(
  parameter logic PRIO_RESET = 1'b0,
  parameter int   CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       req,
  input  logic [3:0]       op0,
  input  logic [3:0]       op1,
  input  logic [31:0]      a0,
  input  logic [31:0]      a1,
  input  logic [31:0]      b0,
  input  logic [31:0]      b1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [31:0]      res_out,
  output logic             res_zf,
  output logic             res_nf,
  output logic             res_of,
  output logic [3:0]       alu_op,
  output logic [31:0]      alu_porta,
  output logic [31:0]      alu_portb,
  input  logic [31:0]      alu_out,
  input  logic             alu_zf,
  input  logic             alu_nf,
  input  logic             alu_of,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic   ptr;
  logic   win;
  assign win  = &req ? ptr : req[1];
  assign busy = state != IDLE;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      ptr       <= PRIO_RESET;
      gnt       <= '0;
      done      <= '0;
      res_out   <= '0;
      res_zf    <= 1'b0;
      res_nf    <= 1'b0;
      res_of    <= 1'b0;
      alu_op    <= '0;
      alu_porta <= '0;
      alu_portb <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          alu_op    <= win ? op1 : op0;
          alu_porta <= win ? a1 : a0;
          alu_portb <= win ? b1 : b0;
          gnt       <= win ? 2'b10 : 2'b01;
          state     <= EXEC;
        end
        EXEC: begin
          res_out  <= alu_out;
          res_zf   <= alu_zf;
          res_nf   <= alu_nf;
          res_of   <= alu_of;
          done     <= gnt;
          gnt      <= '0;
          // the loser of this round holds priority next time
          ptr      <= gnt[0];
          op_count <= &op_count ? op_count : op_count + CNT_W'(1);
          state    <= RESP;
        end
        default: begin
          done  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors, scoreboard queue of expected responses checked on each done pulse.
module tb_alu_arbiter;
  localparam logic [3:0] ADD = 4'd2, SUB = 4'd3, AND_ = 4'd4, OR_ = 4'd5, XOR_ = 4'd6;
  logic CLK = 1'b0, nRST = 1'b0;
  logic [1:0] req = '0;
  logic [3:0] op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [1:0] gnt, done, gnt2, done2;
  logic [31:0] res_out, res_out2;
  logic res_zf, res_nf, res_of, res_zf2, res_nf2, res_of2;
  logic [3:0] alu_op, alu_op2;
  logic [31:0] alu_porta, alu_portb, alu_out, alu_porta2, alu_portb2, alu_out2;
  logic alu_zf, alu_nf, alu_of, alu_zf2, alu_nf2, alu_of2;
  logic [15:0] op_count;
  logic [1:0] op_count2;
  logic busy, busy2;
  int checks = 0, errors = 0, cnt = 0;

  typedef struct {
    logic [1:0]  d;
    logic [31:0] r;
    logic        z, n, o;
    int          c;
  } exp_t;
  exp_t sb[$];

  function automatic logic [34:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic o;
    r = op == ADD ? a + b : op == SUB ? a - b : op == AND_ ? a & b : op == OR_ ? a | b : a ^ b;
    o = op == ADD ? (a[31] == b[31]) && (r[31] != a[31]) :
        op == SUB ? (a[31] != b[31]) && (r[31] != a[31]) : 1'b0;
    return {o, r[31], r == 32'd0, r};
  endfunction

  assign {alu_of, alu_nf, alu_zf, alu_out} = alu_f(alu_op, alu_porta, alu_portb);
  assign {alu_of2, alu_nf2, alu_zf2, alu_out2} = alu_f(alu_op2, alu_porta2, alu_portb2);

  alu_arbiter #(.PRIO_RESET(1'b0), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .op0(op0), .op1(op1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt(gnt), .done(done), .res_out(res_out), .res_zf(res_zf), .res_nf(res_nf), .res_of(res_of),
    .alu_op(alu_op), .alu_porta(alu_porta), .alu_portb(alu_portb), .alu_out(alu_out),
    .alu_zf(alu_zf), .alu_nf(alu_nf), .alu_of(alu_of), .op_count(op_count), .busy(busy));

  alu_arbiter #(.PRIO_RESET(1'b0), .CNT_W(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .req(req), .op0(op0), .op1(op1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt(gnt2), .done(done2), .res_out(res_out2), .res_zf(res_zf2), .res_nf(res_nf2), .res_of(res_of2),
    .alu_op(alu_op2), .alu_porta(alu_porta2), .alu_portb(alu_portb2), .alu_out(alu_out2),
    .alu_zf(alu_zf2), .alu_nf(alu_nf2), .alu_of(alu_of2), .op_count(op_count2), .busy(busy2));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic expect_resp(input logic [1:0] d, input logic [31:0] r, input logic z, input logic n, input logic o);
    exp_t e;
    cnt++;
    e.d = d; e.r = r; e.z = z; e.n = n; e.o = o; e.c = cnt;
    sb.push_back(e);
  endtask

  task automatic run_op(input logic [1:0] r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ez, input logic en, input logic eo, input bit scr);
    req = r;
    op0 = op; a0 = a; b0 = b;
    op1 = op; a1 = a; b1 = b;
    expect_resp(r, er, ez, en, eo);
    tick();
    chk("gnt", {30'd0, gnt}, {30'd0, r});
    chk("busy_exec", {63'd0, busy}, 64'd1);
    req = '0;
    if (scr) begin
      a0 = ~a; b0 = ~b; a1 = ~a; b1 = ~b; op0 = XOR_; op1 = XOR_;
    end
    tick();
    chk("porta_held", {32'd0, alu_porta}, {32'd0, a});
    tick();
  endtask

  always @(negedge CLK) begin
    if (nRST && (done != 2'b00 || done2 != 2'b00)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got %b / %b expected none at %0t", done, done2, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done", {62'd0, done}, {62'd0, e.d});
        chk("res_out", {32'd0, res_out}, {32'd0, e.r});
        chk("flags", {61'd0, res_zf, res_nf, res_of}, {61'd0, e.z, e.n, e.o});
        chk("op_count", {48'd0, op_count}, 64'(e.c));
        chk("sat_done_res", {30'd0, done2, res_out2}, {30'd0, e.d, e.r});
        chk("sat_count", {62'd0, op_count2}, 64'(e.c > 3 ? 3 : e.c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("rst_ctrl", {59'd0, gnt, done, busy}, 64'd0);
    chk("rst_res", {29'd0, res_out, res_zf, res_nf, res_of}, 64'd0);
    chk("rst_alu", {28'd0, alu_op, alu_porta}, 64'd0);
    chk("rst_b_cnt", {16'd0, alu_portb, op_count}, 64'd0);
    nRST = 1'b1;
    tick();
    req = 2'b01; op0 = ADD; a0 = 32'd1; b0 = 32'd1;
    tick();
    chk("abort_gnt", {62'd0, gnt}, 64'd1);
    #2 nRST = 1'b0;
    #1;
    chk("abort_ctrl", {59'd0, gnt, done, busy}, 64'd0);
    chk("abort_alu", {28'd0, alu_op, alu_porta}, 64'd0);
    req = '0;
    tick();
    nRST = 1'b1;
    tick();
    chk("abort_cnt", {48'd0, op_count}, 64'd0);
    req = 2'b11;
    op0 = ADD; a0 = 32'h0000_0005; b0 = 32'h0000_0003;
    op1 = ADD; a1 = 32'h7FFF_FFFF; b1 = 32'h0000_0001;
    expect_resp(2'b01, 32'h8, 1'b0, 1'b0, 1'b0);
    expect_resp(2'b10, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    expect_resp(2'b01, 32'h8, 1'b0, 1'b0, 1'b0);
    expect_resp(2'b10, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk("rr_gnt", {62'd0, gnt}, (j - 1) % 3 != 0 ? 64'd0 : ((j - 1) / 3) % 2 != 0 ? 64'd2 : 64'd1);
    end
    req = '0;
    tick();
    chk("rr_count", {46'd0, op_count2, op_count}, {46'd0, 2'd3, 16'd4});
    run_op(2'b01, ADD, 32'h5, 32'h3, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(2'b10, ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op(2'b01, SUB, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, ADD, 32'd10, 32'd20, 32'h1E, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(2'b10, SUB, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(2'b10, SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 0, 1'b1, 1'b0);
    repeat (4) tick();
    chk("idle_hold_alu", {28'd0, alu_op, alu_porta}, {28'd0, SUB, 32'h8000_0000});
    chk("idle_hold_res", {31'd0, busy, res_out}, {32'd0, 32'h7FFF_FFFF});
    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_resp: got %0d outstanding expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational `alu` datapath between two requesters: req 0 is the execute stage and req 1 is the branch/compare unit.
- Latches the winning requester's operands and drives the ALU from those registers.
- Registers the ALU result and flags, then returns them with a one-cycle done pulse.
- Round-robin arbitration; saturating completed-operation counter for debug/FPGA display.

Parameters:
- PRIO_RESET, 0, requester holding priority after reset (0 or 1).
- CNT_W, 16, width of the op_count performance counter.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- req  input  2  per-requester request level; bit i = requester i.
- op0, op1  input  4  aluop_t opcode from requester 0 / 1.
- a0, a1  input  32  word_t porta operand from requester 0 / 1.
- b0, b1  input  32  word_t portb operand from requester 0 / 1.
- gnt  output  2  one-hot grant, high during EXEC for the served requester.
- done  output  2  one-hot one-cycle completion pulse, high in RESP.
- res_out  output  32  registered ALU result.
- res_zf, res_nf, res_of  output  1 each  registered zero / negative / overflow flags.
- alu_op  output  4  to alu op.
- alu_porta, alu_portb  output  32  to alu porta / portb.
- alu_out  input  32  from alu out.
- alu_zf, alu_nf, alu_of  input  1 each  from alu flags.
- op_count  output  CNT_W  number of completed operations, saturating.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (nRST low, asynchronous):
  - state = IDLE, priority pointer = PRIO_RESET.
  - gnt, done, res_*, alu_op, alu_porta, alu_portb, op_count, busy all 0.
  - Reset mid-operation aborts the operation: no done pulse, no count increment.
- FSM: IDLE -> EXEC -> RESP -> IDLE; each state lasts exactly one cycle.
- IDLE:
  - If any req bit is high, choose the winner:
    - single request -> that requester;
    - both requests -> the requester named by the priority pointer.
  - On the edge, latch the winner's op/a/b into alu_op/alu_porta/alu_portb, set gnt[winner], go to EXEC.
  - If no request, stay in IDLE; ALU-side registers hold their last values.
- EXEC:
  - ALU is driven from the latched registers; gnt stays held.
  - On the edge, capture alu_out/zf/nf/of into res_*, clear gnt, set done[winner], go to RESP.
  - Priority pointer moves to the non-winner.
- RESP:
  - done[winner] is high for this one cycle; res_* are valid and held until the next capture.
  - op_count increments unless already all ones, in which case it holds.
  - req is not sampled; go to IDLE.
- Latency: request seen in IDLE at cycle N -> done at cycle N+2; maximum throughput is one op per 3 cycles.
- Operands are sampled only at grant. The requester may change or drop req/operands after gnt; the operation still completes and done still pulses.
- A requester wanting another op keeps req high through RESP. It is re-eligible in the following IDLE but loses to a pending other requester, because the pointer has moved.
- Under continuous contention, grants strictly alternate 0,1,0,1...; no starvation.
- No arithmetic is performed here; res_* equal exactly the ALU outputs sampled at the end of EXEC.

Test Plan:
- Reset: assert nRST=0 mid-EXEC -> all outputs 0 immediately, no done pulse; after release with PRIO_RESET=0 and req=2'b11 -> gnt=2'b01 first.
- Single op: req=2'b01, op0=ALU_ADD, a0=32'h0000_0005, b0=32'h0000_0003 at cycle N -> gnt=2'b01 at N+1; done=2'b01, res_out=32'h8, zf=nf=of=0, op_count=1 at N+2.
- Overflow/flags: req1 with ALU_ADD, a1=32'h7FFF_FFFF, b1=32'h0000_0001 -> done=2'b10, res_out=32'h8000_0000, of=1, nf=1; ALU_SUB with 5,5 -> res_out=0, zf=1.
- Contention: req=2'b11 held for 12 cycles -> done pulses 01,10,01,10 at 3-cycle spacing; op_count=4.
- Early drop: requester 0 drops req and changes a0 one cycle after gnt -> result still uses the originally latched operands; done=2'b01.
- Saturation with CNT_W=2: run 5 ops -> op_count reads 3,3 after the 3rd and later ops; no wrap to 0.
